// File: rtl/sha256_compress_pkg.sv
// Shared SHA-256 constants, phase codes and round helper functions for the
// compression engine and its round datapath.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXP   = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] PH_IDLE = 3'b000;
  localparam logic [2:0] PH_LOAD = 3'b010;
  localparam logic [2:0] PH_EXP  = 3'b011;

  // Working variables a..h, with a occupying the most significant word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // IV packed the same way as the digest: H0 in the top word.
  localparam logic [255:0] IV_STATE = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-input stream, expander link and digest outputs of the compression
// engine; slave is the engine's view, master the surrounding core's view.
interface sha256_compress_if;

  logic         start_in;
  logic         init_in;
  logic         msg_valid_in;
  logic [31:0]  msg_data_in;
  logic         msg_ready_out;
  logic [2:0]   fsm_me_out;
  logic [6:0]   me_count_out;
  logic [31:0]  me_data_out;
  logic [31:0]  me_w_in;
  logic         busy_out;
  logic [255:0] digest_out;
  logic         digest_valid_out;

  modport slave (
    input  start_in, init_in, msg_valid_in, msg_data_in, me_w_in,
    output msg_ready_out, fsm_me_out, me_count_out, me_data_out,
           busy_out, digest_out, digest_valid_out
  );

  modport master (
    output start_in, init_in, msg_valid_in, msg_data_in, me_w_in,
    input  msg_ready_out, fsm_me_out, me_count_out, me_data_out,
           busy_out, digest_out, digest_valid_out
  );

endinterface

// File: rtl/sha256_compress_round.sv
// Combinational single SHA-256 round: a..h plus K[t] and W[t] in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       nxt
);

  logic [31:0] t1_s;
  logic [31:0] t2_s;

  // Round update; all sums wrap modulo 2^32.
  always_comb begin
    t1_s  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2_s  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1_s + t2_s;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1_s;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: feeds a 16-word block to the message expander,
// runs 64 rounds on the W[t] it returns and folds the result into H.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sha256_compress_if.slave bus
);

  state_t           state_r;
  state_t           state_s;
  logic [6:0]       cnt_r;
  logic [6:0]       cnt_s;
  logic [31:0]      last_word_r;
  logic [7:0][31:0] h_r;
  logic [7:0][31:0] h_sum_s;
  logic [7:0][31:0] work_words_s;
  work_t            work_r;
  work_t            round_s;
  logic [255:0]     digest_r;
  logic             hs_s;
  logic             last_hs_s;

  sha256_round u_round (
    .cur (work_r),
    .k   (K[cnt_r[5:0]]),
    .w   (bus.me_w_in),
    .nxt (round_s)
  );

  // Word handshake, and the one that completes the block.
  always_comb begin
    hs_s      = (state_r == ST_LOAD) && bus.msg_valid_in;
    last_hs_s = hs_s && (cnt_r == 7'd15);
  end

  // Chaining update: H0 sits in the top word of both h_r and work_r.
  always_comb begin
    work_words_s = work_r;
    for (int i = 0; i < 8; i++) begin
      h_sum_s[i] = h_r[i] + work_words_s[i];
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_in) state_s = ST_LOAD;
        else              state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (last_hs_s) state_s = ST_EXP;
        else           state_s = ST_LOAD;
      end
      ST_EXP: begin
        if (cnt_r == 7'd63) state_s = ST_FINAL;
        else                state_s = ST_EXP;
      end
      ST_FINAL: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Counter doubles as accepted-word count in LOAD and round index in EXP.
  always_comb begin
    cnt_s = cnt_r;
    case (state_r)
      ST_LOAD: begin
        if (last_hs_s) cnt_s = 7'd0;
        else if (hs_s) cnt_s = cnt_r + 7'd1;
        else           cnt_s = cnt_r;
      end
      ST_EXP: begin
        if (cnt_r == 7'd63) cnt_s = 7'd0;
        else                cnt_s = cnt_r + 7'd1;
      end
      default: cnt_s = 7'd0;
    endcase
  end

  // Expander-side and status outputs.
  always_comb begin
    bus.fsm_me_out   = PH_IDLE;
    bus.me_count_out = cnt_r;
    bus.me_data_out  = 32'h0000_0000;
    case (state_r)
      ST_LOAD: begin
        if (hs_s) begin
          bus.fsm_me_out   = PH_LOAD;
          bus.me_count_out = cnt_r + 7'd1;
          bus.me_data_out  = bus.msg_data_in;
        end else begin
          bus.fsm_me_out   = PH_IDLE;
          bus.me_count_out = cnt_r;
          bus.me_data_out  = 32'h0000_0000;
        end
      end
      ST_EXP: begin
        bus.fsm_me_out   = PH_EXP;
        bus.me_count_out = cnt_r;
        bus.me_data_out  = last_word_r;
      end
      default: begin
        bus.fsm_me_out   = PH_IDLE;
        bus.me_count_out = cnt_r;
        bus.me_data_out  = 32'h0000_0000;
      end
    endcase
    bus.msg_ready_out    = (state_r == ST_LOAD);
    bus.busy_out         = (state_r != ST_IDLE);
    bus.digest_valid_out = (state_r == ST_DONE);
    bus.digest_out       = digest_r;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 7'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Most recent accepted word, replayed to the expander during EXP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_word_r <= 32'h0000_0000;
    else if (hs_s) last_word_r <= bus.msg_data_in;
    else           last_word_r <= last_word_r;
  end

  // Working variables: seeded from H after the last word, then one round per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  work_r <= '0;
    else if (last_hs_s)          work_r <= work_t'(h_r);
    else if (state_r == ST_EXP)  work_r <= round_s;
    else                         work_r <= work_r;
  end

  // Chaining state: IV on an initialising start, accumulated in FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      h_r <= IV_STATE;
    else if ((state_r == ST_IDLE) && bus.start_in && bus.init_in)
      h_r <= IV_STATE;
    else if (state_r == ST_FINAL)
      h_r <= h_sum_s;
    else
      h_r <= h_r;
  end

  // Digest register only moves in FINAL, so it is zero rather than IV after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   digest_r <= 256'h0;
    else if (state_r == ST_FINAL) digest_r <= h_sum_s;
    else                          digest_r <= digest_r;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Compression engine that sits on the core side of the message-expander interface. It accepts one 512-bit padded block as 16 big-endian 32-bit words over a valid/ready stream, and loads them into the expander with phase code LOAD. It then steps the expander through 64 EXPAND rounds, consuming W[t] each cycle, and finally adds the working variables into the chaining state to produce a 256-bit digest. Multi-block messages are hashed by restarting without re-initialising H.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_in  in  1  begin a block; sampled only in IDLE.
- init_in  in  1  sampled with start_in; 1 = load H from IV first, 0 = chain from current H.
- msg_valid_in  in  1  message word valid.
- msg_data_in  in  32  message word, M[0] first.
- msg_ready_out  out  1  word accepted when valid & ready.
- fsm_me_out  out  3  expander phase: 000 idle, 010 LOAD, 011 EXPAND.
- me_count_out  out  7  expander word/round counter.
- me_data_out  out  32  word to the expander.
- me_w_in  in  32  W[t] from the expander, combinational on count.
- busy_out  out  1  high in any state other than IDLE.
- digest_out  out  256  H0..H7, with H0 in bits [255:224].
- digest_valid_out  out  1  one-cycle pulse when digest_out is updated.

## Operation
- States: IDLE, LOAD, EXP, FINAL, DONE.
- IDLE:
  - fsm_me_out=000, count=0.
  - On start_in, go to LOAD.
  - If init_in=1, H <= IV in the same edge.
- LOAD:
  - msg_ready_out=1.
  - On each handshake k (k=0..15): fsm_me_out=010, me_count_out=k+1, me_data_out=M[k], all in the same cycle.
  - In cycles with no handshake: fsm_me_out=000, count held, me_data_out=0.
  - After the 16th handshake, go to EXP and load a..h <= H.
- EXP:
  - fsm_me_out=011 and me_count_out=t for t=0..63.
  - me_data_out = M[15] (held) throughout.
  - Each edge applies round t, using K[t] and me_w_in:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
    - T2 = Σ0(a) + Maj(a,b,c)
    - Then h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All arithmetic is modulo 2^32; carries are discarded.
  - After t=63, go to FINAL.
- FINAL:
  - fsm_me_out=000.
  - Hi <= Hi + {a..h}i (mod 2^32); digest_out <= the new H.
  - Go to DONE.
- DONE:
  - digest_valid_out=1 for this single cycle.
  - Go to IDLE.
- start_in outside IDLE is ignored. msg_valid_in outside LOAD is ignored, since ready is low.
- digest_out holds its value until the next FINAL.

## Timing
- Reset values:
  - All outputs 0.
  - H = IV; state IDLE; a..h = 0.
  - digest_out = 0, not IV.
- Reset mid-operation aborts immediately. There is no partial digest, and the expander sees 000 on the next cycle.
- start_in high at edge S → LOAD from cycle S+1, and msg_ready_out is high in S+1.
- 16th word accepted at edge N:
  - EXP occupies cycles N+1..N+64.
  - FINAL is cycle N+65.
  - digest_valid_out is high in cycle N+66.
  - IDLE resumes in N+67; a new start can be accepted at the N+67 edge.
- Best-case block time is 16 + 64 + 3 cycles from start to IDLE.
- Stalls in LOAD extend LOAD only. me_count_out never skips or repeats a value for an accepted word.

## Structure
- sha256_pkg holds:
  - K[0:63] constant table, IV[0:7];
  - phase codes PH_IDLE/PH_LOAD/PH_EXP;
  - the functions Σ0, Σ1, Ch, Maj.
- Sub-module sha256_round: combinational one-round update, taking a..h, K, and W and returning the next a..h. The FSM, counters, H registers, and handshake stay in sha256_compress.
- The expander is instantiated beside this block, not inside it.

## Test plan
- Single block "abc":
  - Stimulus: init_in=1, words 61626380, 14×00000000, 00000018.
  - Required: digest_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with digest_valid_out high exactly in cycle N+66.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: init_in=1 for block 1, init_in=0 for block 2.
  - Required: final digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: deassert msg_valid_in randomly during LOAD.
  - Required: me_count_out sequence 1..16 with no gaps; fsm_me_out=000 on idle cycles; digest identical to the "abc" case.
- start_in pulsed during EXP and DONE:
  - Required: ignored, with no state change and unchanged digest.
  - A subsequent start_in in IDLE with init_in=0 chains from the previous H.
- rst_n asserted at round t=30, then the "abc" block rerun:
  - Required: outputs 0 during reset, H=IV, and a correct "abc" digest.
- Interface check during EXP:
  - Required: fsm_me_out=011 with me_count_out 0..63 in consecutive cycles; busy_out low only in IDLE.
